instr_fetch_queue: RTL and testbench

Parametrised instruction-fetch front end that replaces the single-cycle PC / PC+4 / combinational instruction-memory path with a decoupled, pipelined fetch. It issues sequential word fetches to a variable-latency instruction memory and buffers returned instructions with their PCs in a DEPTH-entry queue. A valid/ready handshake feeds decode, and a redirect (jump/branch target) flushes the queue and discards in-flight responses. It sits between the PC-select logic (which produces `redirect_pc`) and the decode stage.

---
 rtl/instr_fetch_queue_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/instr_fetch_queue.sv | 95 +++++++++
 tb/tb_instr_fetch_queue.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_queue_pkg.sv
// rtl/instr_fetch_queue_pkg.sv - shared types and constants for the decoupled instruction fetch front end
package instr_fetch_queue_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } FetchEntry;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry FetchEntry queue with push/pop/flush and wrapping pointers
module fetch_fifo
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  FetchEntry     i_push_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [CW-1:0] o_count,
  output FetchEntry     o_head,
  output logic          o_valid
);

  FetchEntry     r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Storage is cleared on reset so the head outputs read zero straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - credit-based pipelined instruction fetch with redirect flush and response drop
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop_cnt;

  logic [CW-1:0] w_count;
  logic [CW:0]   w_credit_used;
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_rsp;
  logic          w_push;
  logic          w_pop;
  logic          w_head_valid;
  FetchEntry     w_head;
  FetchEntry     w_push_entry;

  // Every accepted request owns a queue slot, so the queue can never overflow.
  assign w_credit_used = {1'b0, r_inflight} + {1'b0, w_count};
  assign w_req_valid   = !reset && !redirect_valid && (w_credit_used < (CW+1)'(DEPTH));
  assign w_req_fire    = w_req_valid && imem_req_ready;
  assign w_rsp         = imem_rsp_valid && (r_inflight != '0);
  assign w_push        = w_rsp && !redirect_valid && (r_drop_cnt == '0);
  assign w_pop         = w_head_valid && instr_ready && !redirect_valid;
  assign w_push_entry  = '{pc: r_rsp_pc, instr: imem_rsp_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_inflight <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_rsp);
      if (redirect_valid) begin
        r_fetch_pc <= align_pc(redirect_pc);
        r_rsp_pc   <= align_pc(redirect_pc);
        r_drop_cnt <= r_inflight - CW'(w_rsp);
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + PC_STEP;
        if (w_rsp) begin
          if (r_drop_cnt != '0) r_drop_cnt <= r_drop_cnt - 1'b1;
          else                  r_rsp_pc   <= r_rsp_pc + PC_STEP;
        end
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_count     (w_count),
    .o_head      (w_head),
    .o_valid     (w_head_valid)
  );

  assign imem_req_valid = w_req_valid;
  assign imem_addr      = r_fetch_pc;
  assign instr_valid    = w_head_valid;
  assign instr          = w_head.instr;
  assign instr_pc       = w_head.pc;

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
    !(imem_rsp_valid && (r_inflight == '0)));
  a_credit_bound: assert property (@(posedge clk) disable iff (reset)
    (w_credit_used <= (CW+1)'(DEPTH)));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - directed self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lat      = 1;
  int last_due = 0;
  int fires    = 0;
  int pops     = 0;
  logic [31:0] exp_pc;

  logic [31:0] mq_addr [$];
  int          mq_due  [$];

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // In-order memory: returns addr>>2 no earlier than lat cycles after acceptance.
  task automatic tick();
    int due;
    if (mq_due.size() != 0 && mq_due[0] == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq_addr[0] >> 2;
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    #1;
    if (imem_req_valid && imem_req_ready) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      mq_addr.push_back(imem_addr);
      mq_due.push_back(due);
      last_due = due;
      fires++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_mem();
    mq_addr.delete();
    mq_due.delete();
    last_due       = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    clear_mem();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    fires = 0;
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    clear_mem();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);

    // free run, L=1
    reset = 1'b0;
    cyc   = 0;
    #1;
    chk("run_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("run_first_addr", imem_addr, 32'h0);
    tick();
    chk("run_cyc1_empty", {31'd0, instr_valid}, 32'd0);
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("run_valid", {31'd0, instr_valid}, 32'd1);
      chk("run_pc", instr_pc, 32'(4 * k));
      chk("run_instr", instr, 32'(k));
      tick();
    end

    // decode stall fills the queue, then drains in order
    instr_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    chk("stall_fires", 32'(fires), 32'd4);
    chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("stall_count", 32'(dut.w_count), 32'd4);
    chk("stall_head_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_valid", {31'd0, instr_valid}, 32'd1);
      chk("drain_pc", instr_pc, 32'(4 * k));
      tick();
    end

    // redirect with three requests in flight, L=4
    lat = 4;
    do_reset();
    repeat (3) tick();
    chk("redir_inflight", 32'(dut.r_inflight), 32'd3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    chk("redir_no_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    chk("redir_drop_cnt", 32'(dut.r_drop_cnt), 32'd3);
    chk("redir_new_addr", imem_addr, 32'h100);
    for (int c = 4; c <= 8; c++) begin
      chk("redir_gap_empty", {31'd0, instr_valid}, 32'd0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      chk("redir_pc", instr_pc, 32'h100 + 32'(4 * k));
      chk("redir_instr", instr, 32'h40 + 32'(k));
      tick();
    end

    // redirect coinciding with a response and a pop, L=2
    lat = 2;
    do_reset();
    repeat (5) tick();
    chk("coin_head_pc", instr_pc, 32'h8);
    chk("coin_inflight", 32'(dut.r_inflight), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    chk("coin_drop_cnt", 32'(dut.r_drop_cnt), 32'd1);
    chk("coin_empty1", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("coin_drop_done", 32'(dut.r_drop_cnt), 32'd0);
    chk("coin_empty2", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("coin_empty3", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("coin_pc0", instr_pc, 32'h200);
    chk("coin_instr0", instr, 32'h80);
    tick();
    chk("coin_pc1", instr_pc, 32'h204);

    // random memory backpressure and latency, random decode stalls
    do_reset();
    exp_pc = 32'h0;
    pops   = 0;
    for (int n = 0; n < 400; n++) begin
      imem_req_ready = ($urandom_range(0, 9) < 6);
      instr_ready    = ($urandom_range(0, 9) < 5);
      lat            = int'($urandom_range(1, 5));
      #1;
      chk("rand_credit", {31'd0, (int'(dut.r_inflight) + int'(dut.w_count)) <= 4}, 32'd1);
      if (instr_valid && instr_ready) begin
        chk("rand_pc", instr_pc, exp_pc);
        chk("rand_instr", instr, exp_pc >> 2);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      tick();
    end
    chk("rand_progress", {31'd0, pops >= 40}, 32'd1);

    // async reset with a partly filled queue and requests in flight
    imem_req_ready = 1'b1;
    instr_ready    = 1'b0;
    lat            = 3;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0400;
    tick();
    redirect_valid = 1'b0;
    repeat (5) tick();
    chk("pre_rst_count", 32'(dut.w_count), 32'd2);
    chk("pre_rst_inflight", 32'(dut.r_inflight), 32'd2);
    chk("pre_rst_pc", instr_pc, 32'h400);
    chk("pre_rst_instr", instr, 32'h100);
    reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, instr_valid}, 32'd0);
    chk("arst_instr", instr, 32'd0);
    chk("arst_pc", instr_pc, 32'd0);
    chk("arst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    clear_mem();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
